// File: rtl/mastermind_board_renderer_if.sv
// Video pixel bus between display_controller, the board renderer and the DACs.
//   bright          active-video flag
//   hCount/vCount   current pixel coordinate
//   vgaR/vgaG/vgaB  4-bit colour outputs
// master: drives the pixel coordinate and observes colour (timing source / bench).
// slave:  consumes the pixel coordinate and produces colour (renderer).
interface mastermind_board_renderer_if;
    logic       bright;
    logic [9:0] hCount;
    logic [9:0] vCount;
    logic [3:0] vgaR;
    logic [3:0] vgaG;
    logic [3:0] vgaB;

    modport master (output bright, hCount, vCount, input vgaR, vgaG, vgaB);
    modport slave  (input bright, hCount, vCount, output vgaR, vgaG, vgaB);
endinterface

// File: rtl/mastermind_board_renderer.sv
// Mastermind board renderer: 3-stage pipelined pixel generator that draws a
// ROWS x COLS grid of circular pegs, highlights the active guess row with a
// 2 px border and blinks a yellow cursor border on the active slot.
//
// Ports:
//   clk          pixel clock
//   rst          synchronous active-high reset
//   vid          pixel bus (slave): bright/hCount/vCount in, vgaR/G/B out
//   matrix_flat  3-bit peg codes, row r col c at [(r*COLS+c)*3 +: 3]
//   fb_flat      per-row feedback {partial, exact}, row r at [r*2*FW +: 2*FW]
//   guess_num    active row index
//   cursor_col   active slot within the active row
//   q_Input      high while the game is waiting for input
//
// Optional feature: define MM_FEEDBACK_EN to draw the feedback squares to the
// right of the grid. Without it fb_flat is ignored and that area is background.
//
// Latency from (bright, hCount, vCount) to vgaR/G/B is 3 clocks.
module mastermind_board_renderer #(
    parameter int ROWS         = 6,
    parameter int COLS         = 4,
    parameter int SLOT         = 48,
    parameter int MARGIN       = 16,
    parameter int RADIUS       = 16,
    parameter int X0           = 300,
    parameter int Y0           = 50,
    parameter int BLINK_FRAMES = 30,
    localparam int RW = $clog2(ROWS),
    localparam int CW = $clog2(COLS),
    localparam int FW = $clog2(COLS + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    mastermind_board_renderer_if.slave vid,
    input  logic [ROWS*COLS*3-1:0]   matrix_flat,
    input  logic [ROWS*2*FW-1:0]     fb_flat,
    input  logic [RW-1:0]            guess_num,
    input  logic [CW-1:0]            cursor_col,
    input  logic                     q_Input
);
    localparam int PITCH  = SLOT + MARGIN;
    localparam int GX1    = X0 + COLS * PITCH - MARGIN;
    localparam int GY1    = Y0 + ROWS * PITCH - MARGIN;
    localparam int HALF   = SLOT / 2;
    localparam int R2     = RADIUS * RADIUS;
    localparam int BW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [11:0] C_BLACK  = 12'h000;
    localparam logic [11:0] C_WHITE  = 12'hFFF;
    localparam logic [11:0] C_YELLOW = 12'hFF0;

    function automatic logic [11:0] palette(input logic [2:0] code);
        case (code)
            3'd1:    palette = 12'h00F;
            3'd2:    palette = 12'h0F0;
            3'd3:    palette = 12'h0FF;
            3'd4:    palette = 12'hF00;
            3'd5:    palette = 12'hFF0;
            3'd6:    palette = 12'hF0F;
            default: palette = 12'h888;
        endcase
    endfunction

    // Square of a signed offset, widened before multiplying so nothing is lost.
    function automatic logic [23:0] square(input logic signed [11:0] a);
        logic signed [23:0] w;
        w = 24'(a);
        square = unsigned'(w * w);
    endfunction

    // ------------------------------------------------------------------
    // Frame tick and cursor blink
    // ------------------------------------------------------------------
    logic          zero_now;
    logic          zero_q;
    logic          tick_q;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;
    logic [RW-1:0] gn_q;
    logic [CW-1:0] cc_q;
    logic          cursor_chg;

    assign zero_now   = (vid.hCount == 10'd0) && (vid.vCount == 10'd0);
    assign cursor_chg = (guess_num != gn_q) || (cursor_col != cc_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q      <= 1'b0;
            tick_q      <= 1'b0;
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
            gn_q        <= '0;
            cc_q        <= '0;
        end else begin
            zero_q <= zero_now;
            tick_q <= zero_now && !zero_q;
            gn_q   <= guess_num;
            cc_q   <= cursor_col;
            // A cursor move restarts the blink with the cursor visible and
            // overrides a tick landing on the same clock.
            if (cursor_chg) begin
                blink_cnt   <= '0;
                blink_phase <= 1'b1;
            end else if (tick_q) begin
                if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: geometry (cell index, offset inside cell) and input capture
    // ------------------------------------------------------------------
    logic [9:0]    hx, vy, dx_c, dy_c;
    logic          h_in, v_in, cell_c;
    logic [CW-1:0] col_c;
    logic [RW-1:0] row_c;

    always_comb begin
        hx     = vid.hCount - 10'(X0);
        vy     = vid.vCount - 10'(Y0);
        h_in   = (int'(vid.hCount) >= X0) && (int'(vid.hCount) < GX1);
        v_in   = (int'(vid.vCount) >= Y0) && (int'(vid.vCount) < GY1);
        col_c  = CW'(int'(hx) / PITCH);
        row_c  = RW'(int'(vy) / PITCH);
        dx_c   = 10'(int'(hx) % PITCH);
        dy_c   = 10'(int'(vy) % PITCH);
        cell_c = h_in && v_in && (int'(dx_c) < SLOT) && (int'(dy_c) < SLOT);
    end

    logic                   vld_p0, cell_p0, hi_p0, cur_p0, phase_p0;
    logic [9:0]             dx_p0, dy_p0;
    logic [CW-1:0]          col_p0;
    logic [RW-1:0]          row_p0;
    logic [ROWS*COLS*3-1:0] mat_p0;

`ifdef MM_FEEDBACK_EN
    localparam int FX     = X0 + COLS * PITCH;
    localparam int FB_W   = COLS * 12 - 4;
    localparam int FB_TOP = (SLOT - 8) / 2;

    logic [9:0]          fx;
    logic                fb_c;
    logic [CW-1:0]       k_c;
    logic                fb_p0;
    logic [CW-1:0]       k_p0;
    logic [ROWS*2*FW-1:0] fbv_p0;

    // Feedback squares: 8 px wide on a 12 px pitch, vertically centred in
    // the row, only for rows already guessed.
    always_comb begin
        fx   = vid.hCount - 10'(FX);
        k_c  = CW'(int'(fx) / 12);
        fb_c = (int'(vid.hCount) >= FX) && (int'(vid.hCount) < FX + FB_W)
            && v_in && (int'(dy_c) >= FB_TOP) && (int'(dy_c) < FB_TOP + 8)
            && ((int'(fx) % 12) < 8) && (row_c < guess_num);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0   <= 1'b0;
            cell_p0  <= 1'b0;
            hi_p0    <= 1'b0;
            cur_p0   <= 1'b0;
            phase_p0 <= 1'b0;
            dx_p0    <= '0;
            dy_p0    <= '0;
            col_p0   <= '0;
            row_p0   <= '0;
            mat_p0   <= '0;
`ifdef MM_FEEDBACK_EN
            fb_p0    <= 1'b0;
            k_p0     <= '0;
            fbv_p0   <= '0;
`endif
        end else begin
            vld_p0   <= vid.bright;
            cell_p0  <= cell_c;
            hi_p0    <= q_Input && (row_c == guess_num);
            cur_p0   <= (col_c == cursor_col);
            phase_p0 <= blink_phase;
            dx_p0    <= dx_c;
            dy_p0    <= dy_c;
            col_p0   <= col_c;
            row_p0   <= row_c;
            mat_p0   <= matrix_flat;
`ifdef MM_FEEDBACK_EN
            fb_p0    <= fb_c;
            k_p0     <= k_c;
            fbv_p0   <= fb_flat;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: distance from cell centre, peg code, border flag
    // ------------------------------------------------------------------
    logic signed [11:0] ox, oy;
    logic [24:0]        d2_c;
    logic [2:0]         code_c;
    logic               border_c;

    always_comb begin
        ox       = $signed({2'b00, dx_p0}) - 12'sd0 - $signed(12'(HALF));
        oy       = $signed({2'b00, dy_p0}) - $signed(12'(HALF));
        d2_c     = {1'b0, square(ox)} + {1'b0, square(oy)};
        code_c   = mat_p0[(int'(row_p0) * COLS + int'(col_p0)) * 3 +: 3];
        border_c = (dx_p0 < 10'd2) || (int'(dx_p0) >= SLOT - 2)
                || (dy_p0 < 10'd2) || (int'(dy_p0) >= SLOT - 2);
    end

    logic        vld_p1, cell_p1, edge_p1, cur_p1, phase_p1;
    logic [24:0] d2_p1;
    logic [2:0]  code_p1;

`ifdef MM_FEEDBACK_EN
    function automatic int sat_exact(input logic [FW-1:0] e);
        sat_exact = (int'(e) > COLS) ? COLS : int'(e);
    endfunction

    logic [11:0] fbrgb_c;
    logic        fb_p1;
    logic [11:0] fbrgb_p1;

    // exact takes precedence: partial only fills the squares left over.
    always_comb begin
        int ex;
        int pa;
        ex = sat_exact(fbv_p0[int'(row_p0) * 2 * FW +: FW]);
        pa = int'(fbv_p0[int'(row_p0) * 2 * FW + FW +: FW]);
        if (int'(k_p0) < ex)           fbrgb_c = 12'hF00;
        else if (int'(k_p0) < ex + pa) fbrgb_c = 12'hFFF;
        else                           fbrgb_c = 12'h444;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            cell_p1  <= 1'b0;
            edge_p1  <= 1'b0;
            cur_p1   <= 1'b0;
            phase_p1 <= 1'b0;
            d2_p1    <= '0;
            code_p1  <= '0;
`ifdef MM_FEEDBACK_EN
            fb_p1    <= 1'b0;
            fbrgb_p1 <= '0;
`endif
        end else begin
            vld_p1   <= vld_p0;
            cell_p1  <= cell_p0;
            edge_p1  <= border_c && hi_p0;
            cur_p1   <= cur_p0;
            phase_p1 <= phase_p0;
            d2_p1    <= d2_c;
            code_p1  <= code_c;
`ifdef MM_FEEDBACK_EN
            fb_p1    <= fb_p0;
            fbrgb_p1 <= fbrgb_c;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: colour select and output register
    // ------------------------------------------------------------------
    logic [11:0] rgb_c;
    logic [11:0] rgb_p2;

    always_comb begin
        rgb_c = C_BLACK;
        if (vld_p1) begin
            if (cell_p1) begin
                if (d2_p1 <= 25'(R2))
                    rgb_c = palette(code_p1);
                else if (edge_p1)
                    rgb_c = (cur_p1 && phase_p1) ? C_YELLOW : C_WHITE;
            end
`ifdef MM_FEEDBACK_EN
            else if (fb_p1) begin
                rgb_c = fbrgb_p1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rgb_p2 <= '0;
        else     rgb_p2 <= rgb_c;
    end

    assign vid.vgaR = rgb_p2[11:8];
    assign vid.vgaG = rgb_p2[7:4];
    assign vid.vgaB = rgb_p2[3:0];
endmodule

// File: tb/tb_mastermind_board_renderer.sv
// Directed bench for mastermind_board_renderer (default parameters).
module tb_mastermind_board_renderer;
    localparam int FW = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [71:0]       matrix_flat;
    logic [6*2*FW-1:0] fb_flat;
    logic [2:0]        guess_num;
    logic [1:0]        cursor_col;
    logic              q_Input;

    always #5 clk = ~clk;

    mastermind_board_renderer_if vid ();

    mastermind_board_renderer dut (
        .clk        (clk),
        .rst        (rst),
        .vid        (vid),
        .matrix_flat(matrix_flat),
        .fb_flat    (fb_flat),
        .guess_num  (guess_num),
        .cursor_col (cursor_col),
        .q_Input    (q_Input)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        b;
        logic [9:0]  h;
        logic [9:0]  v;
        logic        q;
        logic [2:0]  gn;
        logic [1:0]  cc;
        logic [11:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic b, int h, int v, logic q, int gn, int cc,
                                logic [11:0] exp, string name);
        vec_t t;
        t.b = b; t.h = 10'(h); t.v = 10'(v); t.q = q;
        t.gn = 3'(gn); t.cc = 2'(cc); t.exp = exp; t.name = name;
        return t;
    endfunction

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [11:0] exp);
        logic [11:0] act;
        act = {vid.vgaR, vid.vgaG, vid.vgaB};
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: rgb=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic pix(input logic b, input int h, input int v);
        vid.bright = b;
        vid.hCount = 10'(h);
        vid.vCount = 10'(v);
    endtask

    task automatic probe(input string name, input int h, input int v, input logic [11:0] exp);
        pix(1'b1, h, v);
        step(3);
        check(name, exp);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            pix(1'b1, 0, 0);
            step(1);
            pix(1'b1, 1, 0);
            step(1);
        end
    endtask

    task automatic set_code(input int r, input int c, input logic [2:0] code);
        matrix_flat[(r * 4 + c) * 3 +: 3] = code;
    endtask

    task automatic set_fb(input int r, input int exact, input int partial);
        fb_flat[r * 2 * FW +: 2 * FW] = {3'(partial), 3'(exact)};
    endtask

    initial begin
        matrix_flat = '0;
        fb_flat     = '0;
        guess_num   = 3'd0;
        cursor_col  = 2'd0;
        q_Input     = 1'b0;
        set_code(0, 0, 3'd4); set_code(0, 1, 3'd0); set_code(0, 2, 3'd7); set_code(0, 3, 3'd1);
        set_code(1, 0, 3'd2); set_code(1, 1, 3'd3); set_code(1, 2, 3'd5); set_code(1, 3, 3'd6);

        // Reset, then first pixel latency
        pix(1'b1, 324, 74);
        rst = 1'b1;
        step(3);
        check("reset_out", 12'h000);
        rst = 1'b0;
        step(2);
        check("latency_2clk", 12'h000);
        step(1);
        check("latency_3clk", 12'hF00);

        // Table of single-pixel vectors
        vecs.push_back(mk(1, 324,  74, 0, 0, 0, 12'hF00, "code4"));
        vecs.push_back(mk(1, 388,  74, 0, 0, 0, 12'h888, "code0"));
        vecs.push_back(mk(1, 452,  74, 0, 0, 0, 12'h888, "code7"));
        vecs.push_back(mk(1, 516,  74, 0, 0, 0, 12'h00F, "code1"));
        vecs.push_back(mk(1, 324, 138, 0, 0, 0, 12'h0F0, "code2"));
        vecs.push_back(mk(1, 388, 138, 0, 0, 0, 12'h0FF, "code3"));
        vecs.push_back(mk(1, 452, 138, 0, 0, 0, 12'hFF0, "code5"));
        vecs.push_back(mk(1, 516, 138, 0, 0, 0, 12'hF0F, "code6"));
        vecs.push_back(mk(1, 350,  74, 0, 0, 0, 12'h000, "gap_col0_end"));
        vecs.push_back(mk(0, 324,  74, 0, 0, 0, 12'h000, "bright_low"));
        vecs.push_back(mk(1, 299,  74, 0, 0, 0, 12'h000, "left_of_grid"));
        vecs.push_back(mk(1, 540,  74, 0, 0, 0, 12'h000, "right_of_grid"));
        vecs.push_back(mk(1, 340,  74, 0, 0, 0, 12'hF00, "peg_edge_in"));
        vecs.push_back(mk(1, 341,  74, 0, 0, 0, 12'h000, "peg_edge_out"));
        vecs.push_back(mk(1, 300,  74, 0, 0, 0, 12'h000, "ring_no_hilite"));
        vecs.push_back(mk(1, 364, 178, 1, 2, 1, 12'hFF0, "cursor_border"));
        vecs.push_back(mk(1, 428, 178, 1, 2, 1, 12'hFFF, "row_border_col2"));
        vecs.push_back(mk(1, 300, 178, 1, 2, 1, 12'hFFF, "row_border_col0"));
        vecs.push_back(mk(1, 411, 202, 1, 2, 1, 12'hFF0, "cursor_right_edge"));
        vecs.push_back(mk(1, 409, 202, 1, 2, 1, 12'h000, "inner_ring"));
        vecs.push_back(mk(1, 388, 202, 1, 2, 1, 12'h888, "peg_in_hilite_row"));
        vecs.push_back(mk(1, 364, 242, 1, 2, 1, 12'h000, "other_row"));
        vecs.push_back(mk(1, 364, 178, 0, 2, 1, 12'h000, "no_q_input"));
        vecs.push_back(mk(1, 364, 178, 1, 6, 1, 12'h000, "gn_out_of_range"));

        foreach (vecs[i]) begin
            q_Input    = vecs[i].q;
            guess_num  = vecs[i].gn;
            cursor_col = vecs[i].cc;
            pix(vecs[i].b, int'(vecs[i].h), int'(vecs[i].v));
            step(3);
            check(vecs[i].name, vecs[i].exp);
        end

        // Blink: restart the blink by moving the cursor away and back
        q_Input = 1'b1; guess_num = 3'd2;
        cursor_col = 2'd0; step(1);
        cursor_col = 2'd1; step(1);
        probe("blink_start", 364, 178, 12'hFF0);
        ticks(29);
        probe("blink_29", 364, 178, 12'hFF0);
        ticks(1);
        probe("blink_30", 364, 178, 12'hFFF);
        probe("blink_off_col2", 428, 178, 12'hFFF);
        ticks(30);
        probe("blink_60", 364, 178, 12'hFF0);

        // Cursor move on the same clock as the wrapping tick
        ticks(29);
        pix(1'b1, 0, 0);
        step(1);
        pix(1'b1, 1, 0);
        cursor_col = 2'd2;
        step(1);
        probe("chg_wins_cursor", 428, 178, 12'hFF0);
        probe("chg_old_col", 364, 178, 12'hFFF);

        // Held (0,0) counts as one tick
        pix(1'b1, 0, 0);
        step(5);
        pix(1'b1, 1, 0);
        step(1);
        ticks(28);
        probe("held_tick_29", 428, 178, 12'hFF0);
        ticks(1);
        probe("held_tick_30", 428, 178, 12'hFFF);

        // Feedback column
        q_Input = 1'b0; guess_num = 3'd1;
        set_fb(0, 2, 1);
        set_fb(1, 4, 0);
`ifdef MM_FEEDBACK_EN
        probe("fb_sq0", 559, 74, 12'hF00);
        probe("fb_sq1", 571, 74, 12'hF00);
        probe("fb_sq2", 583, 74, 12'hFFF);
        probe("fb_sq3", 595, 74, 12'h444);
        probe("fb_gap", 565, 74, 12'h000);
        probe("fb_row1_unplayed", 559, 138, 12'h000);
        set_fb(0, 3, 3);
        probe("fb_trunc_sq2", 583, 74, 12'hF00);
        probe("fb_trunc_sq3", 595, 74, 12'hFFF);
        set_fb(0, 7, 0);
        probe("fb_sat_sq3", 595, 74, 12'hF00);
`else
        probe("fb_disabled_sq0", 559, 74, 12'h000);
        probe("fb_disabled_sq1", 571, 74, 12'h000);
`endif

        // Reset mid-line and pipeline refill
        probe("pre_rst", 324, 74, 12'hF00);
        rst = 1'b1;
        step(1);
        check("rst_out", 12'h000);
        rst = 1'b0;
        step(1);
        check("rst_refill1", 12'h000);
        step(1);
        check("rst_refill2", 12'h000);
        step(1);
        check("rst_refill3", 12'hF00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
